// File: rtl/upsample_2x_array.sv
// Nearest-neighbour 2x upsampler: each value is doubled horizontally and every
// row of ROW_BEATS beats is emitted twice, the second copy from a line buffer.
//
// state  | meaning
// PASS   | forward input beats to the output and capture them in the line buffer
// REPLAY | re-emit the buffered row; input is stalled
module upsample_2x_array #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_MODULES = 16,
  parameter int ROW_BEATS   = 13
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH*NUM_MODULES-1:0]   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH*NUM_MODULES*2-1:0] out_data,
  output logic                                out_last,
  output logic                                out_copy
);

  localparam int IN_W  = DATA_WIDTH * NUM_MODULES;
  localparam int OUT_W = 2 * IN_W;
  localparam int COL_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_BEATS - 1);

  typedef enum logic {
    ST_PASS   = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             free;
  logic             col_last;
  logic             load;
  logic             load_copy;
  logic             wr_buf;
  logic [IN_W-1:0]  src_data;
  logic [OUT_W-1:0] dup_data;
  logic [IN_W-1:0]  line_buf [ROW_BEATS];

  assign free     = !out_valid || out_ready;
  assign col_last = (col_q == LAST_COL);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    in_ready  = 1'b0;
    load      = 1'b0;
    load_copy = 1'b0;
    wr_buf    = 1'b0;
    src_data  = in_data;
    case (state_q)
      ST_PASS: begin
        in_ready = free;
        if (in_valid && free) begin
          load   = 1'b1;
          wr_buf = 1'b1;
          if (col_last) begin
            col_d   = '0;
            state_d = ST_REPLAY;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_REPLAY: begin
        src_data = line_buf[col_q];
        if (free) begin
          load      = 1'b1;
          load_copy = 1'b1;
          if (col_last) begin
            col_d   = '0;
            state_d = ST_PASS;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  // Horizontal duplication is pure wiring: value i lands in slots 2i and 2i+1.
  for (genvar i = 0; i < NUM_MODULES; i++) begin : g_dup
    assign dup_data[(2*i)*DATA_WIDTH +: DATA_WIDTH]   = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign dup_data[(2*i+1)*DATA_WIDTH +: DATA_WIDTH] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PASS;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // Line buffer holds no reset: a partial row is never replayed after reset.
  always_ff @(posedge clk) begin
    if (wr_buf) line_buf[col_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_copy  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= dup_data;
      out_last  <= col_last;
      out_copy  <= load_copy;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upsample_2x_array.sv
// Bench for upsample_2x_array: directed tables on small instances (ROW_BEATS=2
// and 1) plus a scoreboarded default instance for stall, throughput and random flow.
module tb_upsample_2x_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance: 16 x 16-bit, 13 beats per row
  logic         a_in_valid = 1'b0;
  logic         a_in_ready;
  logic [255:0] a_in_data = '0;
  logic         a_out_valid;
  logic         a_out_ready = 1'b0;
  logic [511:0] a_out_data;
  logic         a_out_last;
  logic         a_out_copy;

  upsample_2x_array u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .out_copy(a_out_copy)
  );

  // small instances share stimulus: 2 x 8-bit, ROW_BEATS 2 (b) and 1 (c)
  logic        s_in_valid = 1'b0;
  logic [15:0] s_in_data = '0;
  logic        s_out_ready = 1'b0;
  logic        b_in_ready, b_out_valid, b_out_last, b_out_copy;
  logic [31:0] b_out_data;
  logic        c_in_ready, c_out_valid, c_out_last, c_out_copy;
  logic [31:0] c_out_data;

  upsample_2x_array #(.DATA_WIDTH(8), .NUM_MODULES(2), .ROW_BEATS(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(b_in_ready), .in_data(s_in_data),
    .out_valid(b_out_valid), .out_ready(s_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_copy(b_out_copy)
  );

  upsample_2x_array #(.DATA_WIDTH(8), .NUM_MODULES(2), .ROW_BEATS(1)) u_dut_c (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(c_in_ready), .in_data(s_in_data),
    .out_valid(c_out_valid), .out_ready(s_out_ready), .out_data(c_out_data),
    .out_last(c_out_last), .out_copy(c_out_copy)
  );

  typedef struct {
    logic [15:0] din;
    logic [31:0] dout;
    logic        last;
    logic        copy;
  } vec_t;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic         copy;
  } exp_t;

  vec_t         small_tab[$];
  logic [255:0] a_iq[$];
  exp_t         a_eq[$];
  int           a_ip = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] dup_a(input logic [255:0] d);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      r[32*i +: 16]      = d[16*i +: 16];
      r[32*i + 16 +: 16] = d[16*i +: 16];
    end
    return r;
  endfunction

  task automatic push_row_a();
    logic [255:0] row [13];
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < 8; k++) row[i][32*k +: 32] = $urandom;
      a_iq.push_back(row[i]);
      a_eq.push_back('{data: dup_a(row[i]), last: (i == 12), copy: 1'b0});
    end
    for (int i = 0; i < 13; i++)
      a_eq.push_back('{data: dup_a(row[i]), last: (i == 12), copy: 1'b1});
  endtask

  task automatic clear_a();
    a_iq.delete();
    a_eq.delete();
    a_ip = 0;
  endtask

  task automatic cycle_a(input logic iv, input logic ordy);
    exp_t e;
    @(negedge clk);
    a_in_valid  = iv && (a_ip < a_iq.size());
    a_in_data   = a_in_valid ? a_iq[a_ip] : '0;
    a_out_ready = ordy;
    #1;
    if (a_out_valid && a_out_ready) begin
      if (a_eq.size() == 0) begin
        chk("a_extra_out", 1'b1, 1'b0);
      end else begin
        e = a_eq.pop_front();
        chk("a_data", a_out_data, e.data);
        chk("a_last", a_out_last, e.last);
        chk("a_copy", a_out_copy, e.copy);
      end
    end
    if (a_in_valid && a_in_ready) a_ip++;
  endtask

  task automatic drain_a(input int budget);
    for (int n = 0; n < budget && a_eq.size() != 0; n++) cycle_a(1'b1, 1'b1);
    chk("a_left_out", a_eq.size(), 0);
    chk("a_left_in", a_ip, a_iq.size());
    a_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b0;
    s_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_small(input logic use_c, input string tag);
    int ip = 0;
    int op = 0;
    int n = small_tab.size();
    logic ov, ir, ol, oc;
    logic [31:0] od;
    for (int cyc = 0; cyc < 40 && op < n; cyc++) begin
      @(negedge clk);
      while (ip < n && small_tab[ip].copy) ip++;
      s_in_valid  = (ip < n);
      s_in_data   = (ip < n) ? small_tab[ip].din : 16'h0;
      s_out_ready = 1'b1;
      #1;
      ov = use_c ? c_out_valid : b_out_valid;
      ir = use_c ? c_in_ready  : b_in_ready;
      ol = use_c ? c_out_last  : b_out_last;
      oc = use_c ? c_out_copy  : b_out_copy;
      od = use_c ? c_out_data  : b_out_data;
      if (ov) begin
        chk({tag, "_data"}, od, small_tab[op].dout);
        chk({tag, "_last"}, ol, small_tab[op].last);
        chk({tag, "_copy"}, oc, small_tab[op].copy);
        op++;
      end
      if (s_in_valid && ir) ip++;
    end
    s_in_valid = 1'b0;
    chk({tag, "_count"}, op, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int first_ov, last_ov, ov_total, irdy_lo;
    logic [511:0] held;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", a_out_valid, 1'b0);
    chk("rst_data", a_out_data, '0);
    chk("rst_last", a_out_last, 1'b0);
    chk("rst_copy", a_out_copy, 1'b0);
    chk("rst_b_valid", b_out_valid, 1'b0);
    rst = 1'b0;

    // duplication, two-beat rows
    small_tab.delete();
    small_tab.push_back('{din: 16'h0102, dout: 32'h01010202, last: 1'b0, copy: 1'b0});
    small_tab.push_back('{din: 16'h0304, dout: 32'h03030404, last: 1'b1, copy: 1'b0});
    small_tab.push_back('{din: 16'h0102, dout: 32'h01010202, last: 1'b0, copy: 1'b1});
    small_tab.push_back('{din: 16'h0304, dout: 32'h03030404, last: 1'b1, copy: 1'b1});
    run_small(1'b0, "dup2");
    do_reset();

    // single-beat rows alternate pass and replay
    small_tab.delete();
    small_tab.push_back('{din: 16'h0A01, dout: 32'h0A0A0101, last: 1'b1, copy: 1'b0});
    small_tab.push_back('{din: 16'h0A01, dout: 32'h0A0A0101, last: 1'b1, copy: 1'b1});
    small_tab.push_back('{din: 16'h0B02, dout: 32'h0B0B0202, last: 1'b1, copy: 1'b0});
    small_tab.push_back('{din: 16'h0B02, dout: 32'h0B0B0202, last: 1'b1, copy: 1'b1});
    small_tab.push_back('{din: 16'h0C03, dout: 32'h0C0C0303, last: 1'b1, copy: 1'b0});
    small_tab.push_back('{din: 16'h0C03, dout: 32'h0C0C0303, last: 1'b1, copy: 1'b1});
    run_small(1'b1, "row1");
    do_reset();

    // asynchronous reset in the middle of a replay
    clear_a();
    push_row_a();
    repeat (16) cycle_a(1'b1, 1'b1);
    chk("pre_rst_copy", a_out_copy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", a_out_valid, 1'b0);
    chk("async_rst_data", a_out_data, '0);
    chk("async_rst_copy", a_out_copy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_a();
    push_row_a();
    drain_a(200);

    // back-pressure: output held for 5 cycles after first beat
    clear_a();
    push_row_a();
    cycle_a(1'b1, 1'b1);
    held = a_eq[0].data;
    for (int i = 0; i < 5; i++) begin
      cycle_a(1'b1, 1'b0);
      chk("bp_valid", a_out_valid, 1'b1);
      chk("bp_data", a_out_data, held);
      chk("bp_in_ready", a_in_ready, 1'b0);
    end
    drain_a(200);

    // full-rate throughput over two rows
    clear_a();
    push_row_a();
    push_row_a();
    first_ov = -1; last_ov = -1; ov_total = 0; irdy_lo = 0;
    for (int c = 0; c < 60; c++) begin
      cycle_a(1'b1, 1'b1);
      if (a_out_valid) begin
        if (first_ov < 0) first_ov = c;
        last_ov = c;
        ov_total++;
      end
      if (!a_in_ready) irdy_lo++;
    end
    chk("tput_out_beats", ov_total, 52);
    chk("tput_no_bubble", last_ov - first_ov + 1, 52);
    chk("tput_first_out", first_ov, 1);
    chk("tput_in_stall", irdy_lo, 26);
    drain_a(10);

    // random valid/ready over 100 rows
    clear_a();
    for (int r = 0; r < 100; r++) push_row_a();
    for (int n = 0; n < 20000 && a_eq.size() != 0; n++)
      cycle_a($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    chk("rand_left_out", a_eq.size(), 0);
    chk("rand_left_in", a_ip, a_iq.size());
    a_in_valid = 1'b0;
    repeat (3) cycle_a(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
